// File: rtl/fg_pkg.sv
// Shared definitions for the waveform-generator DAC output path: FSM encoding,
// default widths and the SPI DAC command prefixes.
package fg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    TAIL,
    CSHIGH,
    LDAC
  } state_t;

  localparam int DAC_BITWIDTH_DEF = 12;
  localparam int CMD_BITWIDTH_DEF = 4;

  localparam logic [3:0] CMD_WRITE_A = 4'b0011;
  localparam logic [3:0] CMD_WRITE_B = 4'b1011;

endpackage

// File: rtl/fg_offset_sat.sv
// Adds a signed DC offset to a signed waveform sample, clamps the result to the
// unsigned WAVEFORM_BITWIDTH range and truncates it to a DAC code.
module fg_offset_sat
  import fg_pkg::*;
#(
  parameter int WAVEFORM_BITWIDTH = 16,
  parameter int DAC_BITWIDTH      = DAC_BITWIDTH_DEF
) (
  input  logic signed [WAVEFORM_BITWIDTH:0] wave,
  input  logic signed [WAVEFORM_BITWIDTH:0] offset,
  output logic        [DAC_BITWIDTH-1:0]    code
);

  localparam int W = WAVEFORM_BITWIDTH;

  logic signed [W+1:0] sum;
  logic        [W-1:0] sat;
  // Bits below the DAC resolution are dropped on purpose (truncation).
  logic                unused_lsbs;

  // NOTE: every combinational output is given a value on every path, so no
  // latch can be inferred.
  always_comb begin
    sum = $signed({wave[W], wave}) + $signed({offset[W], offset});
    if (sum[W+1]) begin
      sat = '0;
    end else if (sum[W]) begin
      sat = '1;
    end else begin
      sat = sum[W-1:0];
    end
    code = sat[W-1 -: DAC_BITWIDTH];
  end

  assign unused_lsbs = ^sat;

endmodule

// File: rtl/fg_dac_spi_tx.sv
// DAC output stage: offset/saturate each strobed sample, shift {cmd, code} out
// on SPI mode 0 (MSB first), then pulse LDAC for one cycle.
module fg_dac_spi_tx
  import fg_pkg::*;
#(
  parameter int WAVEFORM_BITWIDTH = 16,
  parameter int DAC_BITWIDTH      = DAC_BITWIDTH_DEF,
  parameter int CMD_BITWIDTH      = CMD_BITWIDTH_DEF,
  parameter int CLK_DIV           = 2
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          clk_en_i,
  input  logic                          enable_i,
  input  logic signed [WAVEFORM_BITWIDTH:0] wave_i,
  input  logic signed [WAVEFORM_BITWIDTH:0] offset_i,
  input  logic        [CMD_BITWIDTH-1:0]    cmd_i,
  input  logic                          overrun_clr_i,
  output logic                          busy_o,
  output logic                          overrun_o,
  output logic                          sclk_o,
  output logic                          mosi_o,
  output logic                          csn_o,
  output logic                          ldacn_o
);

  localparam int FRAME_BITS = CMD_BITWIDTH + DAC_BITWIDTH;
  localparam int BCW        = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int HCW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BCW-1:0] LAST_BIT    = BCW'(FRAME_BITS - 1);
  localparam logic [HCW-1:0] HALF_RELOAD = HCW'(CLK_DIV - 1);

  logic [DAC_BITWIDTH-1:0] code;
  logic [FRAME_BITS-1:0]   frame;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [HCW-1:0]        half_cnt_q, half_cnt_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  csn_q, csn_d;
  logic                  ldacn_q, ldacn_d;

  logic strobe;
  logic half_done;

  fg_offset_sat #(
    .WAVEFORM_BITWIDTH(WAVEFORM_BITWIDTH),
    .DAC_BITWIDTH     (DAC_BITWIDTH)
  ) u_offset_sat (
    .wave  (wave_i),
    .offset(offset_i),
    .code  (code)
  );

  assign frame     = {cmd_i, code};
  assign strobe    = clk_en_i & enable_i;
  assign half_done = (half_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    half_cnt_d = half_cnt_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;

    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          state_d    = SHIFT;
          shreg_d    = frame;
          mosi_d     = frame[FRAME_BITS-1];
          bit_cnt_d  = LAST_BIT;
          half_cnt_d = HALF_RELOAD;
          sclk_d     = 1'b0;
        end
      end
      SHIFT: begin
        if (!half_done) begin
          half_cnt_d = half_cnt_q - 1'b1;
        end else begin
          half_cnt_d = HALF_RELOAD;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge of SCLK: the only point where MOSI may move.
            sclk_d = 1'b0;
            if (bit_cnt_q == '0) begin
              state_d = TAIL;
              mosi_d  = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q - 1'b1;
              shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
              mosi_d    = shreg_q[FRAME_BITS-2];
            end
          end
        end
      end
      TAIL: begin
        if (!half_done) begin
          half_cnt_d = half_cnt_q - 1'b1;
        end else begin
          half_cnt_d = HALF_RELOAD;
          state_d    = CSHIGH;
        end
      end
      CSHIGH: begin
        if (!half_done) begin
          half_cnt_d = half_cnt_q - 1'b1;
        end else begin
          state_d = LDAC;
        end
      end
      LDAC: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin values are derived from the next state so every output is a flop.
    busy_d  = (state_d != IDLE);
    csn_d   = !(state_d inside {SHIFT, TAIL});
    ldacn_d = (state_d != LDAC);

    // A strobe that cannot be accepted wins over a clear in the same cycle.
    if (strobe && busy_q) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values together.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      csn_q      <= 1'b1;
      ldacn_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      half_cnt_q <= half_cnt_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      csn_q      <= csn_d;
      ldacn_q    <= ldacn_d;
    end
  end

  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign csn_o     = csn_q;
  assign ldacn_o   = ldacn_q;

endmodule

// File: tb/tb_fg_dac_spi_tx.sv
// Directed bench for fg_dac_spi_tx: one instance at CLK_DIV=2, one at CLK_DIV=1,
// each with a pin-level SPI receiver recording frame, busy length and LDAC width.
module tb_fg_dac_spi_tx;
  import fg_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                clk_en[2];
  logic                enable[2];
  logic                overrun_clr[2];
  logic signed [W:0]   wave[2];
  logic signed [W:0]   offset[2];
  logic [3:0]          cmd[2];
  logic                busy[2];
  logic                overrun[2];
  logic                sclk[2];
  logic                mosi[2];
  logic                csn[2];
  logic                ldacn[2];

  int tests = 0;
  int fails = 0;

  fg_dac_spi_tx #(
    .WAVEFORM_BITWIDTH(W), .DAC_BITWIDTH(12), .CMD_BITWIDTH(4), .CLK_DIV(2)
  ) dut0 (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en[0]), .enable_i(enable[0]),
    .wave_i(wave[0]), .offset_i(offset[0]), .cmd_i(cmd[0]),
    .overrun_clr_i(overrun_clr[0]), .busy_o(busy[0]), .overrun_o(overrun[0]),
    .sclk_o(sclk[0]), .mosi_o(mosi[0]), .csn_o(csn[0]), .ldacn_o(ldacn[0])
  );

  fg_dac_spi_tx #(
    .WAVEFORM_BITWIDTH(W), .DAC_BITWIDTH(12), .CMD_BITWIDTH(4), .CLK_DIV(1)
  ) dut1 (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en[1]), .enable_i(enable[1]),
    .wave_i(wave[1]), .offset_i(offset[1]), .cmd_i(cmd[1]),
    .overrun_clr_i(overrun_clr[1]), .busy_o(busy[1]), .overrun_o(overrun[1]),
    .sclk_o(sclk[1]), .mosi_o(mosi[1]), .csn_o(csn[1]), .ldacn_o(ldacn[1])
  );

  // SPI receiver per instance, sampling on the falling clk edge.
  for (genvar g = 0; g < 2; g++) begin : mon
    int          frames = 0;
    int          bits = 0;
    int          last_bits = 0;
    int          busy_run = 0;
    int          last_busy = 0;
    int          ldac_run = 0;
    int          last_ldac = 0;
    int          csn_low = 0;
    int          proto_err = 0;
    logic [15:0] shift_in = '0;
    logic [15:0] last_frame = '0;
    logic        sclk_prev = 1'b0;
    logic        mosi_prev = 1'b0;

    always @(negedge clk) begin
      if (!rstn) begin
        bits = 0;
        busy_run = 0;
        ldac_run = 0;
        sclk_prev = 1'b0;
        mosi_prev = 1'b0;
      end else begin
        if (sclk[g] && !sclk_prev) begin
          shift_in = {shift_in[14:0], mosi[g]};
          bits++;
          if (csn[g]) proto_err++;
        end
        if (sclk[g] && (mosi[g] !== mosi_prev)) proto_err++;
        sclk_prev = sclk[g];
        mosi_prev = mosi[g];
        if (!csn[g]) csn_low++;
        if (busy[g]) begin
          busy_run++;
        end else if (busy_run != 0) begin
          last_busy = busy_run;
          busy_run = 0;
          last_frame = shift_in;
          last_bits = bits;
          bits = 0;
          frames++;
        end
        if (!ldacn[g]) begin
          ldac_run++;
        end else if (ldac_run != 0) begin
          last_ldac = ldac_run;
          ldac_run = 0;
        end
      end
    end
  end

  function automatic int frames_of(input int d);
    return (d == 0) ? mon[0].frames : mon[1].frames;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(input int d, input logic signed [W:0] w,
                        input logic signed [W:0] o, input logic [3:0] c);
    wave[d]   = w;
    offset[d] = o;
    cmd[d]    = c;
    clk_en[d] = 1'b1;
    step();
    clk_en[d] = 1'b0;
  endtask

  task automatic wait_frame(input int d, input int target, input string tag);
    for (int i = 0; i < 600; i++) begin
      if (frames_of(d) >= target) break;
      step();
    end
    check({tag, "_done"}, 32'(frames_of(d) >= target), 32'd1);
  endtask

  task automatic expect_frame(input int d, input string tag, input logic [15:0] exp_frame,
                              input int exp_busy);
    if (d == 0) begin
      check({tag, "_frame"}, 32'(mon[0].last_frame), 32'(exp_frame));
      check({tag, "_bits"},  32'(mon[0].last_bits), 32'd16);
      check({tag, "_busy"},  32'(mon[0].last_busy), 32'(exp_busy));
      check({tag, "_ldac"},  32'(mon[0].last_ldac), 32'd1);
    end else begin
      check({tag, "_frame"}, 32'(mon[1].last_frame), 32'(exp_frame));
      check({tag, "_bits"},  32'(mon[1].last_bits), 32'd16);
      check({tag, "_busy"},  32'(mon[1].last_busy), 32'(exp_busy));
      check({tag, "_ldac"},  32'(mon[1].last_ldac), 32'd1);
    end
  endtask

  initial begin
    int f;
    int c;
    int reached;

    for (int d = 0; d < 2; d++) begin
      clk_en[d] = 1'b0;
      enable[d] = 1'b1;
      overrun_clr[d] = 1'b0;
      wave[d] = '0;
      offset[d] = '0;
      cmd[d] = '0;
    end

    // Reset values
    rstn = 1'b0;
    repeat (3) step();
    check("rst_csn",     32'(csn[0]),     32'd1);
    check("rst_sclk",    32'(sclk[0]),    32'd0);
    check("rst_mosi",    32'(mosi[0]),    32'd0);
    check("rst_ldacn",   32'(ldacn[0]),   32'd1);
    check("rst_busy",    32'(busy[0]),    32'd0);
    check("rst_overrun", 32'(overrun[0]), 32'd0);
    rstn = 1'b1;
    step();

    // Nominal frame: 1000 >> 4 = 0x03E, prefixed with 0011
    strobe(0, 17'sd1000, 17'sd0, CMD_WRITE_A);
    check("acc_busy", 32'(busy[0]), 32'd1);
    check("acc_csn",  32'(csn[0]),  32'd0);
    check("acc_mosi", 32'(mosi[0]), 32'd0);
    check("acc_sclk", 32'(sclk[0]), 32'd0);
    wait_frame(0, 1, "nom");
    expect_frame(0, "nom", 16'h303E, 69);
    check("nom_overrun", 32'(overrun[0]), 32'd0);
    check("nom_idle_csn", 32'(csn[0]), 32'd1);

    // Saturation and offset cases
    f = frames_of(0);
    strobe(0, -17'sd5, 17'sd0, CMD_WRITE_B);
    wait_frame(0, f + 1, "sat_lo");
    expect_frame(0, "sat_lo", 16'hB000, 69);
    strobe(0, 17'sd65535, 17'sd100, CMD_WRITE_B);
    wait_frame(0, f + 2, "sat_hi");
    expect_frame(0, "sat_hi", 16'hBFFF, 69);
    strobe(0, -17'sd200, 17'sd300, CMD_WRITE_B);
    wait_frame(0, f + 3, "ofs");
    expect_frame(0, "ofs", 16'hB006, 69);

    // Overrun: strobe 10 cycles after accept, then clear collides with a strobe
    f = frames_of(0);
    strobe(0, 17'sd1000, 17'sd0, CMD_WRITE_A);
    repeat (9) step();
    strobe(0, 17'sd2000, 17'sd0, CMD_WRITE_B);
    check("ovr_set", 32'(overrun[0]), 32'd1);
    overrun_clr[0] = 1'b1;
    strobe(0, 17'sd3000, 17'sd0, CMD_WRITE_B);
    overrun_clr[0] = 1'b0;
    check("ovr_set_wins", 32'(overrun[0]), 32'd1);
    step();
    check("ovr_sticky", 32'(overrun[0]), 32'd1);
    wait_frame(0, f + 1, "ovr");
    expect_frame(0, "ovr", 16'h303E, 69);
    repeat (5) step();
    check("ovr_no_extra", 32'(frames_of(0)), 32'(f + 1));
    overrun_clr[0] = 1'b1;
    step();
    overrun_clr[0] = 1'b0;
    check("ovr_clr", 32'(overrun[0]), 32'd0);

    // Disabled strobes are ignored
    enable[0] = 1'b0;
    c = mon[0].csn_low;
    f = frames_of(0);
    for (int i = 0; i < 5; i++) begin
      strobe(0, 17'sd1000, 17'sd0, CMD_WRITE_A);
      repeat (3) step();
    end
    check("dis_csn_low", 32'(mon[0].csn_low), 32'(c));
    check("dis_overrun", 32'(overrun[0]),     32'd0);
    check("dis_frames",  32'(frames_of(0)),   32'(f));
    enable[0] = 1'b1;

    // Enable dropped mid-frame: frame still completes with its LDAC pulse
    strobe(0, -17'sd200, 17'sd300, CMD_WRITE_A);
    repeat (5) step();
    enable[0] = 1'b0;
    wait_frame(0, f + 1, "en_drop");
    expect_frame(0, "en_drop", 16'h3006, 69);
    enable[0] = 1'b1;

    // Asynchronous reset while bit 7 is on the wire
    strobe(0, 17'sd1000, 17'sd0, CMD_WRITE_A);
    reached = 0;
    for (int i = 0; i < 200; i++) begin
      if (mon[0].bits == 7) begin
        reached = 1;
        break;
      end
      step();
    end
    check("mid_reached", 32'(reached), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_csn",   32'(csn[0]),   32'd1);
    check("mid_rst_sclk",  32'(sclk[0]),  32'd0);
    check("mid_rst_mosi",  32'(mosi[0]),  32'd0);
    check("mid_rst_ldacn", 32'(ldacn[0]), 32'd1);
    check("mid_rst_busy",  32'(busy[0]),  32'd0);
    step();
    step();
    rstn = 1'b1;
    step();
    f = frames_of(0);
    strobe(0, 17'sd32768, 17'sd0, CMD_WRITE_A);
    wait_frame(0, f + 1, "post_rst");
    expect_frame(0, "post_rst", 16'h3800, 69);

    // CLK_DIV=1: period 36 keeps up with every strobe
    for (int i = 0; i < 4; i++) begin
      logic signed [W:0] w;
      logic signed [W:0] o;
      logic [3:0]        cm;
      logic [15:0]       e;
      case (i)
        0: begin w = 17'sd1000;   o = 17'sd0;   cm = CMD_WRITE_A; e = 16'h303E; end
        1: begin w = -17'sd5;     o = 17'sd0;   cm = CMD_WRITE_B; e = 16'hB000; end
        2: begin w = 17'sd65535;  o = 17'sd100; cm = CMD_WRITE_A; e = 16'h3FFF; end
        default: begin w = -17'sd200; o = 17'sd300; cm = CMD_WRITE_B; e = 16'hB006; end
      endcase
      f = frames_of(1);
      strobe(1, w, o, cm);
      repeat (35) step();
      check("p36_count", 32'(frames_of(1)), 32'(f + 1));
      expect_frame(1, "p36", e, 35);
    end
    check("p36_overrun", 32'(overrun[1]), 32'd0);

    // CLK_DIV=1: period 35 lands on the LDAC cycle and overruns each frame
    for (int k = 0; k < 2; k++) begin
      overrun_clr[1] = 1'b1;
      step();
      overrun_clr[1] = 1'b0;
      check("p35_cleared", 32'(overrun[1]), 32'd0);
      f = frames_of(1);
      strobe(1, 17'sd1000, 17'sd0, CMD_WRITE_A);
      repeat (34) step();
      strobe(1, 17'sd2000, 17'sd0, CMD_WRITE_B);
      check("p35_overrun", 32'(overrun[1]), 32'd1);
      wait_frame(1, f + 1, "p35");
      expect_frame(1, "p35", 16'h303E, 35);
      step();
      check("p35_dropped", 32'(busy[1]), 32'd0);
    end

    check("proto0", 32'(mon[0].proto_err), 32'd0);
    check("proto1", 32'(mon[1].proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fg_dac_spi_tx.md
Name: fg_dac_spi_tx

Overview:
- Output stage directly downstream of the waveform generator.
- Samples the signed waveform value on each sample strobe and adds a signed DC offset.
- Saturates the sum to the unsigned DAC range and truncates it to DAC resolution.
- Serialises a command-plus-data frame to an external SPI DAC (mode 0, MSB first), then pulses LDAC so all channels update synchronously.

Parameters:
- WAVEFORM_BITWIDTH, 16, width of unsigned waveform magnitude; input is WAVEFORM_BITWIDTH+1 bits signed.
- DAC_BITWIDTH, 12, DAC resolution; must be <= WAVEFORM_BITWIDTH.
- CMD_BITWIDTH, 4, command prefix bits; FRAME_BITS = CMD_BITWIDTH + DAC_BITWIDTH.
- CLK_DIV, 2, SCLK half-period in clk_i cycles (H); must be >= 1.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- clk_en_i  in  1  sample strobe, same strobe that advances the waveform generator
- enable_i  in  1  when low, strobes are ignored
- wave_i  in  WAVEFORM_BITWIDTH+1  signed waveform sample
- offset_i  in  WAVEFORM_BITWIDTH+1  signed DC offset
- cmd_i  in  CMD_BITWIDTH  DAC command/channel prefix, captured with the sample
- overrun_clr_i  in  1  clears overrun_o
- busy_o  out  1  frame in progress
- overrun_o  out  1  sticky: strobe arrived while busy
- sclk_o  out  1  SPI clock, idle low
- mosi_o  out  1  SPI data
- csn_o  out  1  chip select, active low
- ldacn_o  out  1  DAC load, active low

Behaviour:
- Reset (async, any time including mid-frame):
  - csn_o=1, sclk_o=0, mosi_o=0, ldacn_o=1, busy_o=0, overrun_o=0, state=IDLE.
  - Any partial frame is abandoned.
- Arithmetic:
  - sum = wave_i + offset_i at WAVEFORM_BITWIDTH+2 bits signed.
  - sum<0 -> 0; sum>2^W-1 -> 2^W-1; otherwise sum.
  - code = sat[W-1 : W-DAC_BITWIDTH], i.e. truncation, no rounding.
  - frame = {cmd_i, code}.
- Accept:
  - In IDLE with clk_en_i=1 and enable_i=1, frame is latched into the shift register at the clock edge.
  - Next cycle: state=SHIFT, busy_o=1, csn_o=0, mosi_o=frame MSB.
  - clk_en_i while busy_o=1 (including the LDAC cycle): sample dropped, overrun_o set.
  - clk_en_i with enable_i=0: ignored, no overrun.
  - enable_i deasserted mid-frame: frame completes normally.
- States:
  - IDLE -> SHIFT on accept.
  - SHIFT: each bit is H cycles sclk_o low, then H cycles high. mosi_o changes only at the start of a low phase; DAC samples on the rising edge. After FRAME_BITS bits -> TAIL.
  - TAIL: sclk_o=0, csn_o=0 for H cycles -> CSHIGH.
  - CSHIGH: csn_o=1 for H cycles -> LDAC.
  - LDAC: ldacn_o=0 for exactly 1 cycle -> IDLE.
- busy_o is high for exactly 2*H*FRAME_BITS + 2*H + 1 cycles (69 at defaults) and low again in the cycle after LDAC.
- Earliest next accept is the first IDLE cycle, so the minimum strobe period is busy length + 1.
- Bit counter holds FRAME_BITS-1..0; half-period counter reloads at H-1. No wrap beyond the frame.
- overrun_o:
  - Set and overrun_clr_i in the same cycle: set wins.
  - Otherwise overrun_clr_i clears it next cycle.
- All outputs are registered; no combinational path from inputs to SPI pins.

Decomposition:
- Shared package fg_pkg holds:
  - state encoding (IDLE, SHIFT, TAIL, CSHIGH, LDAC);
  - default DAC_BITWIDTH/CMD_BITWIDTH;
  - DAC command constants (write-channel-A = 4'b0011, write-channel-B = 4'b1011).
- One combinational sub-module, fg_offset_sat: offset add, clamp, truncate to code. Parameterised by WAVEFORM_BITWIDTH and DAC_BITWIDTH, reusable by the monitor path.
- FSM, counters and shift register stay in the top.

Test Plan:
- Reset mid-SHIFT (bit 7 of a frame): rstn_i low -> outputs at reset values immediately. After release, the next strobe sends a full 16-bit frame.
- wave_i=1000, offset_i=0, cmd_i=4'b0011 -> MOSI frame 0x303E sampled on 16 sclk rising edges. ldacn_o low exactly 1 cycle; busy_o high 69 cycles.
- Saturation:
  - wave_i=-5, offset_i=0 -> code 0x000.
  - wave_i=65535, offset_i=100 -> code 0xFFF.
  - wave_i=-200, offset_i=300 -> code 0x006.
- Strobe 10 cycles after accept -> frame unaffected, overrun_o=1. overrun_clr_i on the same cycle as a further busy strobe -> overrun_o stays 1.
- CLK_DIV=1: back-to-back strobes every 36 cycles (busy=35, 0 idle gaps missed) -> every frame transmitted, no overrun. Strobe period 35 -> overrun every frame.
- enable_i=0 with strobes -> csn_o stays high, no overrun. Drop enable_i mid-frame -> frame and LDAC pulse complete.
